// File: rtl/op_share_arbiter_pkg.sv
// rtl/op_share_arbiter_pkg.sv - shared helpers for operator-sharing arbiters
package op_share_pkg;

    function automatic int tag_width(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

    function automatic bit params_ok(input int k, input int lat);
        return (k >= 1) && (k <= 16) && (lat >= 1) && (lat <= 4);
    endfunction

endpackage

// File: rtl/op_share_arbiter_rr_pick.sv
// rtl/op_share_arbiter_rr_pick.sv - combinational round-robin picker, first request at or after ptr
module rr_pick #(
    parameter int K  = 4,
    parameter int TW = 2
) (
    input  logic [K-1:0]  req,
    input  logic [TW-1:0] ptr,
    output logic          any,
    output logic [TW-1:0] idx,
    output logic [K-1:0]  onehot
);

    int best;
    int d;

    always_comb begin
        best   = K;
        d      = 0;
        idx    = '0;
        onehot = '0;
        // distance from ptr going upward with wrap; smallest distance wins
        for (int j = 0; j < K; j++) begin
            d = (j - int'(ptr) + K) % K;
            if (req[j] && (d < best)) begin
                best = d;
                idx  = TW'(j);
            end
        end
        any = (best < K);
        for (int j = 0; j < K; j++) begin
            onehot[j] = any && (idx == TW'(j));
        end
    end

endmodule

// File: rtl/op_share_arbiter.sv
// rtl/op_share_arbiter.sv - round-robin sharing of one fixed-latency operator among K requesters
module op_share_arbiter #(
    parameter int N   = 16,
    parameter int K   = 4,
    parameter int LAT = 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           EN,
    input  logic [K-1:0]   REQ_R,
    input  logic [K*N-1:0] REQ_D,
    output logic [K-1:0]   REQ_ACK,
    output logic           OP_EN,
    output logic           OP_R_OUT,
    output logic [N-1:0]   OP_D_OUT,
    input  logic           OP_R_IN,
    input  logic [N-1:0]   OP_D_IN,
    output logic [K-1:0]   RES_R,
    output logic [N-1:0]   RES_D,
    output logic           ERR
);
    import op_share_pkg::*;

    localparam int TW = tag_width(K);

    if (!params_ok(K, LAT)) begin : g_param_err
        $error("op_share_arbiter: K must be 1..16 and LAT 1..4");
    end

    logic [TW-1:0] ptr;
    logic          any;
    logic [TW-1:0] g;
    logic [K-1:0]  gnt_oh;
    logic [N-1:0]  req_d_arr [K];
    logic [LAT:0]  tv;
    logic [TW-1:0] tt [0:LAT];
    logic [K-1:0]  res_oh;

    rr_pick #(.K(K), .TW(TW)) u_pick (
        .req    (REQ_R),
        .ptr    (ptr),
        .any    (any),
        .idx    (g),
        .onehot (gnt_oh)
    );

    always_comb begin
        for (int k = 0; k < K; k++) begin
            req_d_arr[k] = REQ_D[k*N +: N];
        end
        for (int j = 0; j < K; j++) begin
            res_oh[j] = (tt[LAT] == TW'(j));
        end
    end

    assign OP_EN = EN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr      <= '0;
            tv       <= '0;
            for (int i = 0; i <= LAT; i++) tt[i] <= '0;
            REQ_ACK  <= '0;
            OP_R_OUT <= 1'b0;
            OP_D_OUT <= '0;
            RES_R    <= '0;
            RES_D    <= '0;
            ERR      <= 1'b0;
        end else if (!EN) begin
            // everything freezes, but pulses must not stretch across the stall
            REQ_ACK <= '0;
            RES_R   <= '0;
        end else begin
            REQ_ACK  <= gnt_oh;
            OP_R_OUT <= any;
            if (any) begin
                OP_D_OUT <= req_d_arr[g];
                ptr      <= (int'(g) == K - 1) ? '0 : g + TW'(1);
            end

            // stage LAT lines up with the operator's R_OUT for the same grant
            tv    <= {tv[LAT-1:0], any};
            tt[0] <= g;
            for (int i = 1; i <= LAT; i++) tt[i] <= tt[i-1];

            RES_R <= '0;
            if (OP_R_IN && tv[LAT]) begin
                RES_R <= res_oh;
                RES_D <= OP_D_IN;
            end else if (OP_R_IN != tv[LAT]) begin
                ERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_op_share_arbiter.sv
// tb/tb_op_share_arbiter.sv - bench for op_share_arbiter, LAT=1 and LAT=3 instances side by side
module tb_op_share_arbiter;

    localparam int NT     = 16;
    localparam int KT     = 4;
    localparam int SLTI_I = 1;

    logic           clk = 1'b0;
    logic           rst, en, frc;
    logic [KT-1:0]  req_r;
    logic [KT*NT-1:0] req_d;

    logic [KT-1:0] ack1, ack3, resr1, resr3;
    logic          open1, open3, opr1, opr3, opi1, opi3, err1, err3;
    logic [NT-1:0] opd1, opd3, opdi1, opdi3, resd1, resd3;

    always #5 clk = ~clk;

    op_share_arbiter #(.N(NT), .K(KT), .LAT(1)) u1 (
        .CLK(clk), .RST(rst), .EN(en), .REQ_R(req_r), .REQ_D(req_d),
        .REQ_ACK(ack1), .OP_EN(open1), .OP_R_OUT(opr1), .OP_D_OUT(opd1),
        .OP_R_IN(opi1), .OP_D_IN(opdi1), .RES_R(resr1), .RES_D(resd1), .ERR(err1)
    );

    op_share_arbiter #(.N(NT), .K(KT), .LAT(3)) u3 (
        .CLK(clk), .RST(rst), .EN(en), .REQ_R(req_r), .REQ_D(req_d),
        .REQ_ACK(ack3), .OP_EN(open3), .OP_R_OUT(opr3), .OP_D_OUT(opd3),
        .OP_R_IN(opi3), .OP_D_IN(opdi3), .RES_R(resr3), .RES_D(resd3), .ERR(err3)
    );

    // compare-immediate operators with latency 1 and 3, frozen by their EN
    logic [3:0] o1v, o1b, o3v, o3b;
    always @(posedge clk) begin
        if (rst) begin
            o1v <= '0; o1b <= '0; o3v <= '0; o3b <= '0;
        end else begin
            if (open1) begin
                o1v <= {o1v[2:0], opr1};
                o1b <= {o1b[2:0], (opd1 < NT'(SLTI_I))};
            end
            if (open3) begin
                o3v <= {o3v[2:0], opr3};
                o3b <= {o3b[2:0], (opd3 < NT'(SLTI_I))};
            end
        end
    end
    assign opi1  = o1v[0] | frc;
    assign opdi1 = {15'd0, o1b[0]};
    assign opi3  = o3v[2] | frc;
    assign opdi3 = {15'd0, o3b[2]};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode = 0;

    int          ecnt = 0;
    int          base = 0;
    int          gtag [0:4095];
    logic        gbit [0:4095];
    int          m_ptr = 0;
    logic [KT-1:0] m_ack = '0;
    logic          m_opr = 1'b0;
    logic [NT-1:0] m_opd = '0;
    logic [KT-1:0] m_resr [2];
    logic [NT-1:0] m_resd [2];
    logic          m_err [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [NT-1:0] d);
        req_r[k] = 1'b1;
        req_d[k*NT +: NT] = d;
    endtask

    task automatic step(input logic en_v, input logic frc_v);
        int g, c, n, lat;
        en = en_v;
        frc = frc_v;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_ptr = 0; m_ack = '0; m_opr = 1'b0; m_opd = '0;
            for (int ii = 0; ii < 2; ii++) begin
                m_resr[ii] = '0; m_resd[ii] = '0; m_err[ii] = 1'b0;
            end
            base = ecnt;
        end else if (!en) begin
            m_ack = '0;
            m_resr[0] = '0;
            m_resr[1] = '0;
        end else begin
            ecnt++;
            // a grant on enabled edge n returns on enabled edge n+LAT+1
            for (int ii = 0; ii < 2; ii++) begin
                lat = (ii == 0) ? 1 : 3;
                n = ecnt - lat - 1;
                if (n > base && gtag[n] >= 0) begin
                    m_resr[ii] = KT'(1 << gtag[n]);
                    m_resd[ii] = {15'd0, gbit[n]};
                end else begin
                    m_resr[ii] = '0;
                    if (frc) m_err[ii] = 1'b1;
                end
            end
            g = -1;
            for (int i = 0; i < KT; i++) begin
                c = (m_ptr + i) % KT;
                if (g < 0 && req_r[c]) g = c;
            end
            gtag[ecnt] = g;
            if (g >= 0) begin
                m_ack = KT'(1 << g);
                m_opr = 1'b1;
                m_opd = req_d[g*NT +: NT];
                m_ptr = (g + 1) % KT;
                gbit[ecnt] = (m_opd < NT'(SLTI_I));
            end else begin
                m_ack = '0;
                m_opr = 1'b0;
            end
        end
        #1;
        chk("ack_l1", 32'(ack1), 32'(m_ack));
        chk("ack_l3", 32'(ack3), 32'(m_ack));
        chk("op_r_l1", 32'(opr1), 32'(m_opr));
        chk("op_r_l3", 32'(opr3), 32'(m_opr));
        chk("op_d_l1", 32'(opd1), 32'(m_opd));
        chk("op_d_l3", 32'(opd3), 32'(m_opd));
        chk("res_r_l1", 32'(resr1), 32'(m_resr[0]));
        chk("res_r_l3", 32'(resr3), 32'(m_resr[1]));
        chk("res_d_l1", 32'(resd1), 32'(m_resd[0]));
        chk("res_d_l3", 32'(resd3), 32'(m_resd[1]));
        chk("err_l1", 32'(err1), 32'(m_err[0]));
        chk("err_l3", 32'(err3), 32'(m_err[1]));
        chk("op_en", 32'(open1), 32'(en));
        frc = 1'b0;
        for (int k = 0; k < KT; k++) begin
            if (mode == 0) begin
                if (m_ack[k]) req_r[k] = 1'b0;
            end else if (mode == 2) begin
                if (req_r[k] && m_ack[k]) begin
                    if ($urandom_range(0, 1) == 1)
                        req_d[k*NT +: NT] = NT'($urandom_range(0, 2));
                    else
                        req_r[k] = 1'b0;
                end else if (!req_r[k] && $urandom_range(0, 2) == 0) begin
                    req_r[k] = 1'b1;
                    req_d[k*NT +: NT] = ($urandom_range(0, 3) == 0) ? NT'($urandom) : NT'($urandom_range(0, 2));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin gtag[i] = -1; gbit[i] = 1'b0; end
        for (int ii = 0; ii < 2; ii++) begin m_resr[ii] = '0; m_resd[ii] = '0; m_err[ii] = 1'b0; end
        rst = 1'b1; en = 1'b1; frc = 1'b0; req_r = '0; req_d = '0;
        step(1, 0); step(1, 0);
        rst = 1'b0;

        // single request, data below and above the immediate
        set_req(0, 16'd0); repeat (5) step(1, 0);
        set_req(0, 16'd5); repeat (5) step(1, 0);

        // all four requesting, held: strict rotation
        mode = 1;
        set_req(0, 16'd0); set_req(1, 16'd3); set_req(2, 16'd0); set_req(3, 16'd9);
        repeat (8) step(1, 0);
        req_r = '0; mode = 0;
        repeat (5) step(1, 0);

        // park pointer at 3, then 0101 wraps 0,2,0
        set_req(2, 16'd0); repeat (2) step(1, 0);
        mode = 1;
        set_req(0, 16'd0); set_req(2, 16'd4);
        repeat (3) step(1, 0);
        req_r = '0; mode = 0;
        repeat (6) step(1, 0);

        // enable stall with one operation in flight
        set_req(1, 16'd0); step(1, 0);
        repeat (3) step(0, 0);
        repeat (8) step(1, 0);

        // unsolicited operator result, then reset clears the sticky error
        step(1, 1);
        repeat (3) step(1, 0);
        rst = 1'b1; step(1, 0); rst = 1'b0;
        repeat (2) step(1, 0);

        // reset with operations in flight, then a clean request
        mode = 1;
        set_req(0, 16'd0); set_req(1, 16'd0); set_req(2, 16'd7); set_req(3, 16'd0);
        repeat (3) step(1, 0);
        req_r = '0; mode = 0;
        rst = 1'b1; step(1, 0); rst = 1'b0;
        repeat (3) step(1, 0);
        set_req(3, 16'd0);
        repeat (7) step(1, 0);

        // random traffic with enable stalls and occasional resets
        mode = 2;
        repeat (300) begin
            rst = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 6) != 0, 1'b0);
        end
        rst = 1'b0; mode = 0; req_r = '0;
        repeat (8) step(1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
